// File: rtl/arith_seq_pkg.sv
// Shared definitions for the arithmetic operation sequencer.
//   state_t  : FSM state encoding (also exported on the 'state' port)
//   OP_*     : op_code values, {fixed, mult}
//   STATE_W  : width of the state encoding
//   CNT_W    : width of the WAIT_RES timeout counter
package arith_seq_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 3'd0,
        S_WAIT_B   = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_RESULT   = 3'd4
    } state_t;

    localparam logic [1:0] OP_FLA = 2'b00;
    localparam logic [1:0] OP_FLM = 2'b01;
    localparam logic [1:0] OP_FIA = 2'b10;
    localparam logic [1:0] OP_FIM = 2'b11;

endpackage

// File: rtl/arith_op_sequencer_if.sv
// Issue/response bus between the sequencer and the operator unit.
//   master : sequencer side (drives op_a/op_b/op_code/op_valid)
//   slave  : operator side (drives op_ready/res_valid/res_data/res_ovf)
interface arith_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       op_code;
    logic             op_valid;
    logic             op_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;

    modport master (
        output op_a, op_b, op_code, op_valid,
        input  op_ready, res_valid, res_data, res_ovf
    );

    modport slave (
        input  op_a, op_b, op_code, op_valid,
        output op_ready, res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/btn_press_enc.sv
// Button press detector and priority encoder.
//   clk, rst  : clock, async active-high reset
//   btn[3:0]  : debounced level buttons
//   press     : one-cycle pulse on the rising edge of any button
//   press_op  : op_code of the lowest-index rising button
// btn_q clears on reset, so a button held through reset release is seen
// as a fresh press in the first cycle after release.
module btn_press_enc
    import arith_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       press,
    output logic [1:0] press_op
);
    logic [3:0] btn_q;
    logic [3:0] rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_q <= 4'b0;
        else     btn_q <= btn;
    end

    assign rise  = btn & ~btn_q;
    assign press = |rise;

    // Lowest index wins; remaining simultaneous rises are dropped.
    always_comb begin
        press_op = OP_FLA;
        if      (rise[0]) press_op = OP_FLA;
        else if (rise[1]) press_op = OP_FLM;
        else if (rise[2]) press_op = OP_FIA;
        else if (rise[3]) press_op = OP_FIM;
    end
endmodule

// File: rtl/arith_op_sequencer.sv
// Arithmetic operation sequencer: captures two operands from switches on
// button presses, issues them to an operator unit, waits for the result
// (with timeout) and holds it for display.
//   clk, rst     : clock, async active-high reset
//   sw           : operand switches
//   btn[3:0]     : float add / float mult / fixed add / fixed mult
//   bus          : operator issue/response interface (master side)
//   result, overflow, timeout_err : captured response
//   state        : current FSM state, disp_en : high only in RESULT
// Optional build macro ARITH_SEQ_CHAIN_EN: a press in RESULT reloads op_a
// from the result and goes straight to WAIT_B (accumulator chaining).
// Without it, a press in RESULT clears all data and returns to IDLE.
module arith_op_sequencer
    import arith_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       sw,
    input  logic [3:0]             btn,
    arith_op_sequencer_if.master   bus,
    output logic [WIDTH-1:0]       result,
    output logic                   overflow,
    output logic                   timeout_err,
    output logic [STATE_W-1:0]     state,
    output logic                   disp_en
);
    // Counter starts at 0 in the first WAIT_RES cycle, so the abort fires
    // on the TIMEOUT-th cycle when it holds TIMEOUT-1.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [1:0]       op_code_q;
    logic             op_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press;
    logic [1:0]       press_op;

    btn_press_enc u_btn (
        .clk      (clk),
        .rst      (rst),
        .btn      (btn),
        .press    (press),
        .press_op (press_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_code_q   <= OP_FLA;
            op_valid_q  <= 1'b0;
            cnt_q       <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            disp_en     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press) begin
                        op_a_q  <= sw;
                        state_q <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (press) begin
                        op_b_q     <= sw;
                        op_code_q  <= press_op;
                        op_valid_q <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (op_valid_q && bus.op_ready) begin
                        op_valid_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    // A response in the abort cycle still wins.
                    if (bus.res_valid) begin
                        result      <= bus.res_data;
                        overflow    <= bus.res_ovf;
                        timeout_err <= 1'b0;
                        disp_en     <= 1'b1;
                        state_q     <= S_RESULT;
                    end else if (cnt_q == TO_LAST) begin
                        result      <= '0;
                        overflow    <= 1'b0;
                        timeout_err <= 1'b1;
                        disp_en     <= 1'b1;
                        state_q     <= S_RESULT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESULT: begin
                    if (press) begin
`ifdef ARITH_SEQ_CHAIN_EN
                        op_a_q      <= result;
                        op_b_q      <= '0;
                        timeout_err <= 1'b0;
                        disp_en     <= 1'b0;
                        state_q     <= S_WAIT_B;
`else
                        op_a_q      <= '0;
                        op_b_q      <= '0;
                        result      <= '0;
                        overflow    <= 1'b0;
                        timeout_err <= 1'b0;
                        disp_en     <= 1'b0;
                        state_q     <= S_IDLE;
`endif
                    end
                end
                default: begin
                    op_valid_q <= 1'b0;
                    disp_en    <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_code  = op_code_q;
    assign bus.op_valid = op_valid_q;
    assign state        = state_q;
endmodule

// File: tb/tb_arith_op_sequencer.sv
module tb_arith_op_sequencer;
    localparam int W  = 16;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw  = '0;
    logic [3:0]   btn = '0;
    logic [W-1:0] result;
    logic         overflow, timeout_err, disp_en;
    logic [2:0]   state;

    int n_chk  = 0;
    int n_fail = 0;

    arith_op_sequencer_if #(.WIDTH(W)) bus ();

    arith_op_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .btn         (btn),
        .bus         (bus.master),
        .result      (result),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .state       (state),
        .disp_en     (disp_en)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; btn = '0; sw = '0;
        bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.res_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic press(input logic [3:0] m, input logic [W-1:0] v);
        sw = v; btn = m;
        tick();
        btn = '0;
    endtask

    task automatic to_issue(input logic [W-1:0] a, input logic [3:0] ma,
                            input logic [W-1:0] b, input logic [3:0] mb);
        press(ma, a);
        tick();
        press(mb, b);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.res_ovf = 1'b0;
        tick(); tick();
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_chk++; if ({bus.op_a, bus.op_b, result} !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h %h %h want 0", bus.op_a, bus.op_b, result); end
        n_chk++; if ({bus.op_code, bus.op_valid, overflow, timeout_err, disp_en} !== 6'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000000", {bus.op_code, bus.op_valid, overflow, timeout_err, disp_en}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [W-1:0] d;
        do_reset();
        d = W'($urandom);
        bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res_data = d; bus.res_ovf = 1'b1;
        press(4'b0100, 16'h1234);
        n_chk++; if ({state, bus.op_a} !== {3'd1, 16'h1234}) begin n_fail++; $display("FAIL basic_first: got st=%0d a=%h want 1 1234", state, bus.op_a); end
        tick();
        press(4'b0100, 16'h0011);
        n_chk++; if ({state, bus.op_valid, bus.op_code} !== {3'd2, 1'b1, 2'b10}) begin n_fail++;
            $display("FAIL basic_issue: got st=%0d v=%b code=%b want 2 1 10", state, bus.op_valid, bus.op_code); end
        n_chk++; if ({bus.op_a, bus.op_b} !== {16'h1234, 16'h0011}) begin n_fail++; $display("FAIL basic_ops: got %h %h want 1234 0011", bus.op_a, bus.op_b); end
        n_chk++; if (result !== 16'h0) begin n_fail++; $display("FAIL basic_res_ignored: got %h want 0", result); end
        tick();
        n_chk++; if ({state, bus.op_valid} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL basic_waitres: got st=%0d v=%b want 3 0", state, bus.op_valid); end
        tick();
        n_chk++; if ({state, result, overflow, timeout_err, disp_en} !== {3'd4, d, 1'b1, 1'b0, 1'b1}) begin n_fail++;
            $display("FAIL basic_result: got st=%0d r=%h o=%b t=%b de=%b want 4 %h 1 0 1", state, result, overflow, timeout_err, disp_en, d); end
    endtask

    task automatic test_priority();
        int trans;
        logic [2:0] prev;
        do_reset();
        press(4'b0001, 16'h0001);
        tick();
        press(4'b1010, 16'h0002);
        n_chk++; if ({state, bus.op_code} !== {3'd2, 2'b01}) begin n_fail++; $display("FAIL prio_code: got st=%0d code=%b want 2 01", state, bus.op_code); end
        do_reset();
        sw = 16'h00AA; btn = 4'b0010;
        trans = 0; prev = state;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (state !== prev) trans++;
            prev = state;
        end
        btn = '0;
        n_chk++; if (trans !== 1) begin n_fail++; $display("FAIL hold_one_press: got %0d transitions want 1", trans); end
        n_chk++; if ({state, bus.op_a} !== {3'd1, 16'h00AA}) begin n_fail++; $display("FAIL hold_state: got st=%0d a=%h want 1 00aa", state, bus.op_a); end
    endtask

    task automatic test_ready_stall();
        logic [W-1:0] a, b, d;
        do_reset();
        a = W'($urandom); b = W'($urandom); d = W'($urandom);
        bus.op_ready = 1'b0; bus.res_valid = 1'b1; bus.res_data = d; bus.res_ovf = 1'b0;
        to_issue(a, 4'b1000, b, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            n_chk++; if ({state, bus.op_valid, bus.op_a, bus.op_b, bus.op_code, result} !== {3'd2, 1'b1, a, b, 2'b11, 16'h0}) begin n_fail++;
                $display("FAIL stall_cycle%0d: got st=%0d v=%b a=%h b=%h c=%b r=%h want 2 1 %h %h 11 0", i, state, bus.op_valid, bus.op_a, bus.op_b, bus.op_code, result, a, b); end
            btn = (i == 2) ? 4'b0001 : 4'b0000;
            tick();
        end
        btn = '0;
        n_chk++; if (state !== 3'd2) begin n_fail++; $display("FAIL stall_still_issue: got %0d want 2", state); end
        bus.op_ready = 1'b1;
        tick();
        n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL stall_release: got %0d want 3", state); end
        tick();
        n_chk++; if ({state, result} !== {3'd4, d}) begin n_fail++; $display("FAIL stall_result: got st=%0d r=%h want 4 %h", state, result, d); end
    endtask

    task automatic test_timeout();
        int wc;
        logic [W-1:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            d = W'($urandom_range(1, 65535));
            bus.op_ready = 1'b1; bus.res_valid = 1'b0; bus.res_data = d; bus.res_ovf = 1'b1;
            to_issue(16'h0003, 4'b0001, 16'h0004, 4'b0001);
            tick();
            wc = 0;
            while (state == 3'd3 && wc < 50) begin
                wc++;
                btn = (wc == 2) ? 4'b0100 : 4'b0000;
                bus.res_valid = (pass == 1) && (wc == TO);
                tick();
            end
            btn = '0; bus.res_valid = 1'b0;
            n_chk++; if (wc !== TO) begin n_fail++; $display("FAIL timeout_cycles_p%0d: got %0d want %0d", pass, wc, TO); end
            if (pass == 0) begin
                n_chk++; if ({state, result, overflow, timeout_err, disp_en} !== {3'd4, 16'h0, 1'b0, 1'b1, 1'b1}) begin n_fail++;
                    $display("FAIL timeout_abort: got st=%0d r=%h o=%b t=%b de=%b want 4 0 0 1 1", state, result, overflow, timeout_err, disp_en); end
            end else begin
                n_chk++; if ({state, result, overflow, timeout_err} !== {3'd4, d, 1'b1, 1'b0}) begin n_fail++;
                    $display("FAIL timeout_late_resp: got st=%0d r=%h o=%b t=%b want 4 %h 1 0", state, result, overflow, timeout_err, d); end
            end
        end
    endtask

    task automatic test_result_press();
        do_reset();
        bus.op_ready = 1'b1; bus.res_valid = 1'b1; bus.res_data = 16'h0042; bus.res_ovf = 1'b0;
        to_issue(16'h0040, 4'b0100, 16'h0002, 4'b0100);
        tick(); tick();
        n_chk++; if ({state, result} !== {3'd4, 16'h0042}) begin n_fail++; $display("FAIL rp_result: got st=%0d r=%h want 4 0042", state, result); end
        press(4'b0001, 16'hBEEF);
`ifdef ARITH_SEQ_CHAIN_EN
        n_chk++; if ({state, bus.op_a, bus.op_b, timeout_err} !== {3'd1, 16'h0042, 16'h0, 1'b0}) begin n_fail++;
            $display("FAIL rp_chain: got st=%0d a=%h b=%h t=%b want 1 0042 0 0", state, bus.op_a, bus.op_b, timeout_err); end
`else
        n_chk++; if ({state, bus.op_a, bus.op_b, result, overflow, timeout_err, disp_en} !== {3'd0, 48'h0, 3'b0}) begin n_fail++;
            $display("FAIL rp_clear: got st=%0d a=%h b=%h r=%h flags=%b want 0 all zero", state, bus.op_a, bus.op_b, result, {overflow, timeout_err, disp_en}); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.op_ready = 1'b1; bus.res_valid = 1'b0; bus.res_data = 16'h7777;
        to_issue(16'h1111, 4'b0010, 16'h2222, 4'b0010);
        tick(); tick();
        n_chk++; if (state !== 3'd3) begin n_fail++; $display("FAIL rmid_pre: got %0d want 3", state); end
        #2;
        rst = 1'b1; btn = 4'b0001; sw = 16'h5A5A;
        #1;
        n_chk++; if ({state, bus.op_a, bus.op_b, result, bus.op_code, bus.op_valid, overflow, timeout_err, disp_en} !== {3'd0, 48'h0, 6'b0}) begin n_fail++;
            $display("FAIL rmid_async: got st=%0d a=%h b=%h r=%h flags=%b want all zero", state, bus.op_a, bus.op_b, result,
                     {bus.op_code, bus.op_valid, overflow, timeout_err, disp_en}); end
        tick();
        rst = 1'b0;
        n_chk++; if (state !== 3'd0) begin n_fail++; $display("FAIL rmid_release: got %0d want 0", state); end
        tick();
        n_chk++; if ({state, bus.op_a} !== {3'd1, 16'h5A5A}) begin n_fail++; $display("FAIL rmid_held_btn: got st=%0d a=%h want 1 5a5a", state, bus.op_a); end
        btn = '0;
    endtask

    // Transaction-level model: operands come straight from sw, op_code is the
    // lowest pressed button, ISSUE lasts ready-delay+1 cycles, WAIT_RES lasts
    // min(response-delay+1, TO) cycles and a response beyond TO is an abort.
    task automatic test_random();
        logic [W-1:0] a, b, data, exp_res;
        logic [3:0] ma, mb;
        logic [1:0] exp_code;
        logic ovf, to_flag, exp_ovf;
        int d, r, gap, ic, wc, exp_wait;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            a = W'($urandom); b = W'($urandom); data = W'($urandom);
            ma = 4'($urandom_range(1, 15)); mb = 4'($urandom_range(1, 15));
            ovf = 1'($urandom_range(0, 1));
            d = int'($urandom_range(0, 3)); r = int'($urandom_range(0, 6)); gap = int'($urandom_range(1, 3));
            exp_code = 2'd0;
            for (int k = 3; k >= 0; k--) if (mb[k]) exp_code = 2'(k);
            to_flag  = (r + 1 > TO);
            exp_wait = to_flag ? TO : r + 1;
            exp_res  = to_flag ? 16'h0 : data;
            exp_ovf  = to_flag ? 1'b0 : ovf;

            bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = data; bus.res_ovf = ovf;
            press(ma, a);
            repeat (gap) tick();
            press(mb, b);
            n_chk++; if ({state, bus.op_a, bus.op_b, bus.op_code} !== {3'd2, a, b, exp_code}) begin n_fail++;
                $display("FAIL rnd%0d_issue: got st=%0d a=%h b=%h c=%b want 2 %h %h %b", it, state, bus.op_a, bus.op_b, bus.op_code, a, b, exp_code); end
            ic = 0;
            while (state == 3'd2 && ic < 50) begin
                ic++;
                bus.op_ready = (ic == d + 1);
                tick();
            end
            bus.op_ready = 1'b0;
            n_chk++; if (ic !== d + 1) begin n_fail++; $display("FAIL rnd%0d_issue_len: got %0d want %0d", it, ic, d + 1); end
            wc = 0;
            while (state == 3'd3 && wc < 50) begin
                wc++;
                bus.res_valid = (wc == r + 1);
                tick();
            end
            bus.res_valid = 1'b0;
            n_chk++; if (wc !== exp_wait) begin n_fail++; $display("FAIL rnd%0d_wait_len: got %0d want %0d", it, wc, exp_wait); end
            n_chk++; if ({state, result, overflow, timeout_err, disp_en} !== {3'd4, exp_res, exp_ovf, to_flag, 1'b1}) begin n_fail++;
                $display("FAIL rnd%0d_result: got st=%0d r=%h o=%b t=%b de=%b want 4 %h %b %b 1", it, state, result, overflow, timeout_err, disp_en,
                         exp_res, exp_ovf, to_flag); end
        end
    endtask

    initial begin
        bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0; bus.res_ovf = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_ready_stall();
        test_timeout();
        test_result_press();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule
